rgb_tx_scheduler: RTL and testbench
===================================

RGB_TX_SCHEDULER -- requirements
Module: rgb_tx_scheduler

Interface
REQ-001 Parameter SLOT_CYCLES, default 500: cycles per serialized byte slot; legal range 1..1365.
REQ-002 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req0_valid  in  1  requester 0 offers a pixel.
REQ-005 req0_rgb  in  24  requester 0 pixel; [23:16]=R, [15:8]=G, [7:0]=B.
REQ-006 req0_ready  out  1  requester 0 pixel accepted this cycle when req0_valid is also high.
REQ-007 req1_valid, req1_rgb, req1_ready: same as REQ-004..006, for requester 1.
REQ-008 flush  in  1  abort the current hold window.
REQ-009 px_valid  out  1  one-cycle pixel-load strobe to the RGB byte serializer.
REQ-010 r_out, g_out, b_out  out  8 each  pixel bytes to the serializer.
REQ-011 grant_id  out  1  index of the requester that owns the pixel on r/g/b_out.
REQ-012 busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, ISSUE, HOLD.
REQ-014 In IDLE with flush low, the FSM SHALL drive ready combinationally to exactly one arbitration winner among the valid requesters, and SHALL assert no ready when neither requester is valid.
REQ-015 A transfer SHALL occur on a cycle where valid and ready are both high. On that edge the block SHALL register r/g/b_out and grant_id from the winner, and the FSM SHALL move to ISSUE.
REQ-016 In ISSUE, px_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then move to HOLD. Flush cannot suppress this strobe.
REQ-017 HOLD SHALL last exactly 3*SLOT_CYCLES cycles, counted by a 12-bit counter from 0 to 3*SLOT_CYCLES-1. After the last count the FSM SHALL return to IDLE.
REQ-018 Latency: for a transfer at cycle N, px_valid SHALL be high at N+1. The next transfer SHALL be possible no earlier than N+2+3*SLOT_CYCLES.
REQ-019 r/g/b_out and grant_id SHALL remain stable from the transfer until the next transfer.
REQ-020 Round-robin arbitration:
- When both requesters are valid, the winner SHALL be the requester opposite last_grant.
- When only one requester is valid, that requester SHALL win.
- last_grant SHALL update only on a transfer.
REQ-021 A flush in HOLD SHALL force IDLE on the next edge and clear the counter.
REQ-022 A flush in ISSUE SHALL force IDLE instead of HOLD.
REQ-023 A flush in IDLE SHALL block acceptance for that cycle.
REQ-024 ready SHALL be low in ISSUE and HOLD. A requester holding valid high SHALL keep its data until it is accepted, with no loss or duplication.

Reset
REQ-025 On sys_rst_n low, the block SHALL immediately set: state=IDLE, counter=0, px_valid=0, r/g/b_out=0, grant_id=0, busy=0, last_grant=1.
- last_grant=1 makes requester 0 win the first contention.
REQ-026 Reset asserted mid-HOLD or mid-ISSUE SHALL abandon the pixel with no further strobe.
REQ-027 After reset release, acceptance SHALL be possible on the first clock edge.

Configuration
REQ-028 With macro RGB_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: requester 0 always wins contention, and last_grant is unused.
REQ-029 Without RGB_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-020.
REQ-030 The port list and timing SHALL be identical in both builds.

Verification (SLOT_CYCLES=4, hold=12)
REQ-031 Single requester: req0_valid with rgb=0x112233 at cycle 0. Required response:
- ready0=1 at cycle 0.
- px_valid=1 at cycle 1, with r/g/b_out=11/22/33 and grant_id=0.
- busy=1 for cycles 1..13.
- Next acceptance possible at cycle 14.
REQ-032 Contention after reset: both requesters valid continuously, rgb0=0xA0A0A0, rgb1=0xB0B0B0. Required response:
- Grants in the order 0,1,0,1.
- px_valid at cycles 1, 15, 29, 43.
- With RGB_SCHED_FIXED_PRIO_EN: grants 0,0,0,0.
REQ-033 Flush: flush pulsed at cycle 5 of HOLD (after an accept at cycle 0). Required response:
- busy=0 at cycle 7.
- With req1 valid, accept at cycle 7 and px_valid at cycle 8.
REQ-034 Backpressure: req1_valid raised at cycle 3 during HOLD. Required response:
- ready1=0 until cycle 14.
- Accept at cycle 14, single px_valid at cycle 15.
REQ-035 Reset at cycle 6 of HOLD. Required response:
- All outputs zero immediately.
- No px_valid after release.
- First post-reset contention granted to requester 0.

Source files
------------

// File: rtl/rgb_tx_scheduler.sv
`timescale 1ns/1ps
// rgb_tx_scheduler
// Arbitrates two 24-bit pixel requesters onto one RGB byte serializer.
// An accepted pixel is registered and announced with a one-cycle px_valid
// strobe (ISSUE). The block then waits 3*SLOT_CYCLES cycles (HOLD) so the
// serializer can shift out R, G and B before the next pixel is accepted.
//
// Build option: define RGB_SCHED_FIXED_PRIO_EN for fixed priority
// (requester 0 always wins contention). Without it, arbitration is
// round-robin. Ports and timing are identical in both builds.
//
// Handshake: a requester raises reqN_valid with reqN_rgb and holds both
// until it sees reqN_ready high in the same cycle; the pixel transfers on
// that rising edge. ready is a combinational function of state, flush and
// the valids (never of ready itself), and is only ever given to one requester.
module rgb_tx_scheduler #(
  parameter int SLOT_CYCLES = 500  // cycles per serialized byte, 1..1365
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req0_valid,
  input  logic [23:0] req0_rgb,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_rgb,
  output logic        req1_ready,
  input  logic        flush,
  output logic        px_valid,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        grant_id,
  output logic        busy
);

  // Three byte slots per pixel; the counter runs 0 .. HOLD_LAST.
  localparam int          HOLD_LEN  = 3 * SLOT_CYCLES;
  localparam logic [11:0] HOLD_LAST = 12'(HOLD_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [11:0] hold_cnt_q;
  logic        hold_done;
  logic        accept_en;
  logic        pick1;
  logic        xfer;
  logic [23:0] sel_rgb;

`ifndef RGB_SCHED_FIXED_PRIO_EN
  // Requester that won the most recent transfer; reset to 1 so that
  // requester 0 wins the first contention.
  logic        last_grant_q;
`endif

  // Arbitration: pick1 is high when requester 1 is the winner.
  always_comb begin
`ifdef RGB_SCHED_FIXED_PRIO_EN
    pick1 = req1_valid & ~req0_valid;
`else
    pick1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif
  end

  assign accept_en  = (state_q == ST_IDLE) & ~flush;
  assign req0_ready = accept_en & req0_valid & ~pick1;
  assign req1_ready = accept_en & pick1;
  assign xfer       = req0_ready | req1_ready;
  assign sel_rgb    = pick1 ? req1_rgb : req0_rgb;
  assign hold_done  = (hold_cnt_q == HOLD_LAST);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush aborts ISSUE/HOLD but never the strobe itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (xfer) state_d = ST_ISSUE;
      ST_ISSUE: state_d = flush ? ST_IDLE : ST_HOLD;
      ST_HOLD:  if (flush || hold_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    px_valid = 1'b0;
    busy     = 1'b0;
    if (state_q == ST_ISSUE) px_valid = 1'b1;
    if (state_q != ST_IDLE)  busy     = 1'b1;
  end

  // Hold counter: advances only while staying in HOLD, otherwise cleared.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt_q <= '0;
    end else if (state_q == ST_HOLD && state_d == ST_HOLD) begin
      hold_cnt_q <= hold_cnt_q + 12'd1;
    end else begin
      hold_cnt_q <= '0;
    end
  end

  // Pixel and owner registers; only a transfer changes them.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
      grant_id <= 1'b0;
    end else if (xfer) begin
      r_out    <= sel_rgb[23:16];
      g_out    <= sel_rgb[15:8];
      b_out    <= sel_rgb[7:0];
      grant_id <= pick1;
    end
  end

`ifndef RGB_SCHED_FIXED_PRIO_EN
  // Round-robin history, updated only on a transfer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_grant_q <= 1'b1;
    end else if (xfer) begin
      last_grant_q <= pick1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_tx_scheduler.sv
`timescale 1ns/1ps
// Directed bench for rgb_tx_scheduler with SLOT_CYCLES=4 (hold of 12 cycles).
// Cycle k runs from rising edge k to rising edge k+1; inputs change 1ns after
// the edge, outputs are sampled on the falling edge.
module tb_rgb_tx_scheduler;

  localparam int SLOT = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [23:0] req0_rgb = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [23:0] req1_rgb = '0;
  logic        req1_ready;
  logic        flush = 1'b0;
  logic        px_valid;
  logic [7:0]  r_out, g_out, b_out;
  logic        grant_id;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  rgb_tx_scheduler #(.SLOT_CYCLES(SLOT)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req0_valid (req0_valid),
    .req0_rgb   (req0_rgb),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rgb   (req1_rgb),
    .req1_ready (req1_ready),
    .flush      (flush),
    .px_valid   (px_valid),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // Clock and watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (busy === 1'b1 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
    end
    step();
  endtask

  // Reset values
  task automatic test_reset();
    do_reset();
    @(negedge sys_clk);
    tests_run++;
    if ({px_valid, busy, grant_id} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl px_valid/busy/grant=%b required 000", {px_valid, busy, grant_id});
    end
    tests_run++;
    if ({r_out, g_out, b_out} !== 24'h000000) begin
      tests_failed++;
      $display("FAIL reset_rgb got %h required 000000", {r_out, g_out, b_out});
    end
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready got %b required 00", {req0_ready, req1_ready});
    end
    step();
  endtask

  // Single requester, latency and hold length
  task automatic test_single();
    req0_valid = 1'b1;
    req0_rgb   = 24'h112233;
    @(negedge sys_clk);
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_ready got %b required 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    @(negedge sys_clk);
    tests_run++;
    if ({px_valid, busy, grant_id, r_out, g_out, b_out} !== {3'b110, 24'h112233}) begin
      tests_failed++;
      $display("FAIL single_issue got px=%b busy=%b gid=%b rgb=%h required 1 1 0 112233",
               px_valid, busy, grant_id, {r_out, g_out, b_out});
    end
    for (int c = 2; c <= 13; c++) begin
      step();
      @(negedge sys_clk);
      tests_run++;
      if ({busy, px_valid, r_out, g_out, b_out} !== {2'b10, 24'h112233}) begin
        tests_failed++;
        $display("FAIL single_hold_c%0d got busy=%b px=%b rgb=%h required 1 0 112233",
                 c, busy, px_valid, {r_out, g_out, b_out});
      end
    end
    step();
    req0_valid = 1'b1;
    req0_rgb   = 24'h445566;
    @(negedge sys_clk);
    tests_run++;
    if ({busy, req0_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_reaccept_c14 got busy=%b ready0=%b required 0 1", busy, req0_ready);
    end
    step();
    req0_valid = 1'b0;
    @(negedge sys_clk);
    tests_run++;
    if ({px_valid, r_out, g_out, b_out} !== {1'b1, 24'h445566}) begin
      tests_failed++;
      $display("FAIL single_second_px got px=%b rgb=%h required 1 445566", px_valid, {r_out, g_out, b_out});
    end
    wait_idle("single");
  endtask

  // Contention after reset
  task automatic test_contention();
    int   px_cyc[$];
    logic gids[$];
    int   exp_cyc[4];
    logic exp_gid[4];
    exp_cyc = '{1, 15, 29, 43};
`ifdef RGB_SCHED_FIXED_PRIO_EN
    exp_gid = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_gid = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    req0_valid = 1'b1;
    req0_rgb   = 24'hA0A0A0;
    req1_valid = 1'b1;
    req1_rgb   = 24'hB0B0B0;
    for (int c = 0; c < 46; c++) begin
      @(negedge sys_clk);
      if (c == 0) begin
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
          tests_failed++;
          $display("FAIL contention_first_ready got %b required 10", {req0_ready, req1_ready});
        end
      end
      if (px_valid === 1'b1) begin
        px_cyc.push_back(c);
        gids.push_back(grant_id);
        tests_run++;
        if ({r_out, g_out, b_out} !== (grant_id ? 24'hB0B0B0 : 24'hA0A0A0)) begin
          tests_failed++;
          $display("FAIL contention_data_c%0d got %h for grant %b", c, {r_out, g_out, b_out}, grant_id);
        end
      end
      step();
    end
    tests_run++;
    if (px_cyc.size() != 4) begin
      tests_failed++;
      $display("FAIL contention_strobe_count got %0d required 4", px_cyc.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= px_cyc.size()) begin
        tests_failed++;
        $display("FAIL contention_grant%0d missing required cycle %0d", i, exp_cyc[i]);
      end else if (px_cyc[i] != exp_cyc[i] || gids[i] !== exp_gid[i]) begin
        tests_failed++;
        $display("FAIL contention_grant%0d got cycle %0d id %b required cycle %0d id %b",
                 i, px_cyc[i], gids[i], exp_cyc[i], exp_gid[i]);
      end
    end
    idle_inputs();
    wait_idle("contention");
  endtask

  // Flush in IDLE, HOLD and ISSUE
  task automatic test_flush();
    req0_valid = 1'b1;
    req0_rgb   = 24'h5A5A5A;
    flush      = 1'b1;
    @(negedge sys_clk);
    tests_run++;
    if (req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle_block ready0=%b required 0", req0_ready);
    end
    step();
    flush = 1'b0;  // cycle 0
    @(negedge sys_clk);
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_accept ready0=%b required 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;  // cycle 1
    step();
    req1_valid = 1'b1;  // cycle 2
    req1_rgb   = 24'hC0FFEE;
    step();
    step();
    step();
    step();
    flush = 1'b1;  // cycle 6, fifth HOLD cycle
    @(negedge sys_clk);
    tests_run++;
    if ({busy, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL flush_hold_c6 got busy=%b ready1=%b required 1 0", busy, req1_ready);
    end
    step();
    flush = 1'b0;  // cycle 7
    @(negedge sys_clk);
    tests_run++;
    if ({busy, req1_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_hold_c7 got busy=%b ready1=%b required 0 1", busy, req1_ready);
    end
    step();
    req1_valid = 1'b0;  // cycle 8: ISSUE, flush raised here
    flush      = 1'b1;
    @(negedge sys_clk);
    tests_run++;
    if ({px_valid, grant_id, r_out, g_out, b_out} !== {2'b11, 24'hC0FFEE}) begin
      tests_failed++;
      $display("FAIL flush_issue_strobe got px=%b gid=%b rgb=%h required 1 1 c0ffee",
               px_valid, grant_id, {r_out, g_out, b_out});
    end
    step();
    flush = 1'b0;  // cycle 9
    @(negedge sys_clk);
    tests_run++;
    if ({busy, px_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_issue_to_idle got busy=%b px=%b required 0 0", busy, px_valid);
    end
    wait_idle("flush");
  endtask

  // Backpressure during HOLD
  task automatic test_back_to_back();
    int n_px;
    req0_valid = 1'b1;  // cycle 0
    req0_rgb   = 24'h010203;
    step();
    req0_valid = 1'b0;  // cycle 1
    step();
    step();
    req1_valid = 1'b1;  // cycle 3
    req1_rgb   = 24'h0A0B0C;
    for (int c = 3; c <= 13; c++) begin
      @(negedge sys_clk);
      tests_run++;
      if (req1_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_c%0d ready1=%b required 0", c, req1_ready);
      end
      step();
    end
    @(negedge sys_clk);  // cycle 14
    tests_run++;
    if (req1_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_accept_c14 ready1=%b required 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;  // cycle 15
    @(negedge sys_clk);
    tests_run++;
    if ({px_valid, grant_id, r_out, g_out, b_out} !== {2'b11, 24'h0A0B0C}) begin
      tests_failed++;
      $display("FAIL backpressure_px_c15 got px=%b gid=%b rgb=%h required 1 1 0a0b0c",
               px_valid, grant_id, {r_out, g_out, b_out});
    end
    n_px = 0;
    for (int c = 16; c <= 30; c++) begin
      step();
      @(negedge sys_clk);
      if (px_valid === 1'b1) n_px++;
    end
    tests_run++;
    if (n_px != 0) begin
      tests_failed++;
      $display("FAIL backpressure_duplicate extra strobes=%0d required 0", n_px);
    end
    step();
    wait_idle("backpressure");
  endtask

  // Reset in the middle of HOLD
  task automatic test_reset_mid_hold();
    int n_px;
    req0_valid = 1'b1;  // cycle 0, leaves last grant on requester 0
    req0_rgb   = 24'h778899;
    step();
    req0_valid = 1'b0;
    for (int c = 1; c < 6; c++) step();
    sys_rst_n = 1'b0;  // cycle 6
    #1;
    tests_run++;
    if ({px_valid, busy, grant_id, r_out, g_out, b_out} !== 27'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold got px=%b busy=%b gid=%b rgb=%h required all 0",
               px_valid, busy, grant_id, {r_out, g_out, b_out});
    end
    step();
    step();
    sys_rst_n = 1'b1;
    n_px = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (px_valid === 1'b1) n_px++;
      step();
    end
    tests_run++;
    if (n_px != 0) begin
      tests_failed++;
      $display("FAIL reset_no_strobe strobes=%0d required 0", n_px);
    end
    req0_valid = 1'b1;
    req0_rgb   = 24'hDDEEFF;
    req1_valid = 1'b1;
    req1_rgb   = 24'h123456;
    @(negedge sys_clk);
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_first_contention got %b required 10", {req0_ready, req1_ready});
    end
    step();
    idle_inputs();
    @(negedge sys_clk);
    tests_run++;
    if ({px_valid, grant_id, r_out, g_out, b_out} !== {2'b10, 24'hDDEEFF}) begin
      tests_failed++;
      $display("FAIL reset_first_px got px=%b gid=%b rgb=%h required 1 0 ddeeff",
               px_valid, grant_id, {r_out, g_out, b_out});
    end
    wait_idle("reset_mid_hold");
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_flush();
    test_back_to_back();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
